ibex_rvfi_trace_buffer: RTL and testbench
=========================================

IBEX_RVFI_TRACE_BUFFER -- requirements
Module: ibex_rvfi_trace_buffer

Interface
REQ-001 SHALL have parameter Depth, default 8, FIFO entries; power of two, 2..64.
REQ-002 SHALL have parameter DropCntWidth, default 16, width of the dropped-record counter.
REQ-003 SHALL have port clk_i, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port enable_i, input, 1, capture enable; when low, the block accepts no retirements.
REQ-006 SHALL have port flush_i, input, 1, synchronous clear of FIFO contents and drop counter.
REQ-007 SHALL have port rvfi_valid, input, 1, retirement strobe.
REQ-008 SHALL have ports rvfi_pc_rdata and rvfi_insn, input, 32 each, retired PC and instruction.
REQ-009 SHALL have ports rvfi_rd_addr (5) and rvfi_rd_wdata (32), inputs, destination register and write data.
REQ-010 SHALL have ports rvfi_trap, rvfi_intr and rvfi_ext_debug_mode, inputs, 1 each, retirement flags.
REQ-011 SHALL have port trace_valid_o, output, 1, head record present.
REQ-012 SHALL have port trace_ready_i, input, 1, consumer accepts the head record.
REQ-013 SHALL have port trace_rec_o, output, trace_rec_t, head record.
REQ-014 SHALL have port level_o, output, $clog2(Depth)+1, occupancy.
REQ-015 SHALL have port drop_cnt_o, output, DropCntWidth, count of dropped records.

Function
REQ-016 SHALL push a record on the clk_i edge where rvfi_valid && enable_i && !flush_i && (not full, or pop in the same cycle).
REQ-017 SHALL pop on the clk_i edge where trace_valid_o && trace_ready_i.
REQ-018 SHALL present a record pushed into an empty FIFO on trace_valid_o at the next cycle; latency is 1 cycle; there is no combinational input-to-output path.
REQ-019 SHALL hold trace_rec_o stable while trace_valid_o && !trace_ready_i.
REQ-020 SHALL, when full with no pop, drop the record and increment drop_cnt_o, saturating at all-ones.
REQ-021 SHALL set the lost flag in the next accepted record after any drop; the flag clears once that record is written.
REQ-022 SHALL update level_o as level + push - pop; a simultaneous push and pop leaves it unchanged, including at full and at empty-with-bypass-disallowed (empty: pop impossible).
REQ-023 SHALL wrap the read and write pointers modulo Depth; full and empty are derived from level.
REQ-024 SHALL give flush_i priority over push and pop: next cycle level_o=0, drop_cnt_o=0, lost flag=0.
REQ-025 SHALL NOT count a retirement as dropped when enable_i=0.

Reset
REQ-026 SHALL set trace_valid_o=0, level_o=0, drop_cnt_o=0, trace_rec_o=0, pointers=0 and lost flag=0 while rst_i=1; reset mid-transfer discards contents.

Configuration
REQ-027 SHALL, with IBEX_TRACE_TSTAMP_EN defined, add a 32-bit free-running cycle counter (reset 0, wraps) and capture its value at push into trace_rec_t.tstamp.
REQ-028 SHALL, without IBEX_TRACE_TSTAMP_EN, omit the tstamp field and the counter; all other behaviour is identical.

Structure
REQ-029 SHALL declare trace_rec_t (pc, insn, rd_addr, rd_wdata, trap, intr, dbg, lost, optional tstamp) in package ibex_trace_pkg.
REQ-030 SHALL place storage in the sub-module ibex_trace_fifo_mem (Depth x trace_rec_t, 1 write port, 1 read port, registered).

Verification
REQ-031 SHALL cover: empty, push pc=0x100 at cycle 0 -> trace_valid_o=1 at cycle 1, trace_rec_o.pc=0x100, level_o=1.
REQ-032 SHALL cover: Depth=8, ready=0, 10 pushes -> level_o=8, drop_cnt_o=2; then pop once and push pc=0x200 -> that record has lost=1.
REQ-033 SHALL cover: full, push and pop in the same cycle -> level_o stays 8, drop_cnt_o unchanged, order preserved.
REQ-034 SHALL cover: level_o=5, flush_i with rvfi_valid=1 -> next cycle level_o=0, trace_valid_o=0, drop_cnt_o=0.
REQ-035 SHALL cover: DropCntWidth=4, 20 drops -> drop_cnt_o=0xF.
REQ-036 SHALL cover: IBEX_TRACE_TSTAMP_EN defined, pushes at cycles 3 and 7 after reset -> tstamp values 3 and 7.

Source files
------------

// File: rtl/ibex_trace_pkg.sv
// Trace record type shared by the RVFI trace buffer and its storage.
// Defining IBEX_TRACE_TSTAMP_EN appends a 32-bit cycle timestamp to every record.
package ibex_trace_pkg;

`ifdef IBEX_TRACE_TSTAMP_EN
    localparam int unsigned TstampWidth = 32;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic        trap;
        logic        intr;
        logic        dbg;
        logic        lost;
`ifdef IBEX_TRACE_TSTAMP_EN
        logic [TstampWidth-1:0] tstamp;
`endif
    } trace_rec_t;

endpackage

// File: rtl/ibex_trace_fifo_mem.sv
// Depth x trace_rec_t storage with one write port and one registered read port.
// The read port forwards same-cycle write data so a record pushed into an empty FIFO appears one cycle later.
module ibex_trace_fifo_mem
    import ibex_trace_pkg::*;
#(
    parameter int unsigned Depth = 8,
    parameter int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  trace_rec_t       wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output trace_rec_t       rdata_o
);

    trace_rec_t mem_r [Depth];
    trace_rec_t rdata_r;

    // Storage write port
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_r[waddr_i] <= wdata_i;
        end
    end

    // Registered read port with write-through forwarding
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            rdata_r <= '0;
        end else if (we_i && (waddr_i == raddr_i)) begin
            rdata_r <= wdata_i;
        end else begin
            rdata_r <= mem_r[raddr_i];
        end
    end

    assign rdata_o = rdata_r;

endmodule

// File: rtl/ibex_rvfi_trace_buffer.sv
// RVFI retirement trace buffer: queues retired instructions, counts and flags records lost on overflow.
// Define IBEX_TRACE_TSTAMP_EN to stamp each record with a free-running 32-bit cycle counter.
module ibex_rvfi_trace_buffer
    import ibex_trace_pkg::*;
#(
    parameter int unsigned Depth        = 8,
    parameter int unsigned DropCntWidth = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic                    flush_i,
    input  logic                    rvfi_valid,
    input  logic [31:0]             rvfi_pc_rdata,
    input  logic [31:0]             rvfi_insn,
    input  logic [4:0]              rvfi_rd_addr,
    input  logic [31:0]             rvfi_rd_wdata,
    input  logic                    rvfi_trap,
    input  logic                    rvfi_intr,
    input  logic                    rvfi_ext_debug_mode,
    output logic                    trace_valid_o,
    input  logic                    trace_ready_i,
    output trace_rec_t              trace_rec_o,
    output logic [$clog2(Depth):0]  level_o,
    output logic [DropCntWidth-1:0] drop_cnt_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned LvlW = PtrW + 1;
    localparam logic [LvlW-1:0] LvlFull = LvlW'(Depth);
    localparam logic [DropCntWidth-1:0] DropMax = {DropCntWidth{1'b1}};

    logic [PtrW-1:0]         rd_ptr_r, rd_ptr_next_s;
    logic [PtrW-1:0]         wr_ptr_r, wr_ptr_next_s;
    logic [LvlW-1:0]         level_r, level_next_s;
    logic [DropCntWidth-1:0] drop_cnt_r, drop_cnt_next_s;
    logic                    valid_r;
    logic                    lost_r, lost_next_s;
    logic                    full_s, capture_s, push_s, pop_s, drop_s;
    trace_rec_t              wr_rec_s;

`ifdef IBEX_TRACE_TSTAMP_EN
    logic [TstampWidth-1:0] tstamp_r;

    // Free-running cycle counter, only reset clears it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tstamp_r <= 32'd0;
        end else begin
            tstamp_r <= tstamp_r + 32'd1;
        end
    end
`endif

    // Handshake qualification; flush suppresses both push and pop
    always_comb begin
        full_s    = (level_r == LvlFull);
        capture_s = rvfi_valid && enable_i && !flush_i;
        pop_s     = valid_r && trace_ready_i && !flush_i;
        push_s    = capture_s && (!full_s || pop_s);
        drop_s    = capture_s && full_s && !pop_s;
    end

    // Record assembly from the retirement interface
    always_comb begin
        wr_rec_s          = '0;
        wr_rec_s.pc       = rvfi_pc_rdata;
        wr_rec_s.insn     = rvfi_insn;
        wr_rec_s.rd_addr  = rvfi_rd_addr;
        wr_rec_s.rd_wdata = rvfi_rd_wdata;
        wr_rec_s.trap     = rvfi_trap;
        wr_rec_s.intr     = rvfi_intr;
        wr_rec_s.dbg      = rvfi_ext_debug_mode;
        wr_rec_s.lost     = lost_r;
`ifdef IBEX_TRACE_TSTAMP_EN
        wr_rec_s.tstamp   = tstamp_r;
`endif
    end

    // Next-state for pointers, occupancy, drop counter and lost flag
    always_comb begin
        rd_ptr_next_s   = rd_ptr_r;
        wr_ptr_next_s   = wr_ptr_r;
        level_next_s    = level_r;
        drop_cnt_next_s = drop_cnt_r;
        lost_next_s     = lost_r;
        if (flush_i) begin
            rd_ptr_next_s   = '0;
            wr_ptr_next_s   = '0;
            level_next_s    = '0;
            drop_cnt_next_s = '0;
            lost_next_s     = 1'b0;
        end else begin
            if (pop_s) begin
                rd_ptr_next_s = rd_ptr_r + PtrW'(1'b1);
            end else begin
                rd_ptr_next_s = rd_ptr_r;
            end
            if (push_s) begin
                wr_ptr_next_s = wr_ptr_r + PtrW'(1'b1);
            end else begin
                wr_ptr_next_s = wr_ptr_r;
            end
            level_next_s = level_r + LvlW'(push_s) - LvlW'(pop_s);
            // A drop marks the next accepted record; writing that record clears the mark
            if (drop_s) begin
                lost_next_s = 1'b1;
                if (drop_cnt_r != DropMax) begin
                    drop_cnt_next_s = drop_cnt_r + DropCntWidth'(1'b1);
                end else begin
                    drop_cnt_next_s = drop_cnt_r;
                end
            end else if (push_s) begin
                lost_next_s = 1'b0;
            end else begin
                lost_next_s = lost_r;
            end
        end
    end

    // State registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            level_r    <= '0;
            drop_cnt_r <= '0;
            lost_r     <= 1'b0;
            valid_r    <= 1'b0;
        end else begin
            rd_ptr_r   <= rd_ptr_next_s;
            wr_ptr_r   <= wr_ptr_next_s;
            level_r    <= level_next_s;
            drop_cnt_r <= drop_cnt_next_s;
            lost_r     <= lost_next_s;
            valid_r    <= (level_next_s != '0);
        end
    end

    // Read address is the next head so the registered read port always shows the current head
    ibex_trace_fifo_mem #(
        .Depth (Depth)
    ) u_mem (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (flush_i),
        .we_i    (push_s),
        .waddr_i (wr_ptr_r),
        .wdata_i (wr_rec_s),
        .raddr_i (rd_ptr_next_s),
        .rdata_o (trace_rec_o)
    );

    assign trace_valid_o = valid_r;
    assign level_o       = level_r;
    assign drop_cnt_o    = drop_cnt_r;

endmodule

// File: tb/tb_ibex_rvfi_trace_buffer.sv
// Scoreboard bench for ibex_rvfi_trace_buffer (Depth=8, DropCntWidth=4); tstamp checks
// are active when IBEX_TRACE_TSTAMP_EN is defined.
module tb_ibex_rvfi_trace_buffer;
    import ibex_trace_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable_i, flush_i, rvfi_valid;
    logic [31:0] rvfi_pc_rdata, rvfi_insn, rvfi_rd_wdata;
    logic [4:0]  rvfi_rd_addr;
    logic        rvfi_trap, rvfi_intr, rvfi_ext_debug_mode;
    logic        trace_valid_o, trace_ready_i;
    trace_rec_t  trace_rec_o;
    logic [3:0]  level_o;
    logic [3:0]  drop_cnt_o;

    typedef struct {
        logic [104:0] bits;
        logic         ts_chk;
        logic [31:0]  ts;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   nchk = 0;
    int   nerr = 0;

    ibex_rvfi_trace_buffer #(.Depth(8), .DropCntWidth(4)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .enable_i            (enable_i),
        .flush_i             (flush_i),
        .rvfi_valid          (rvfi_valid),
        .rvfi_pc_rdata       (rvfi_pc_rdata),
        .rvfi_insn           (rvfi_insn),
        .rvfi_rd_addr        (rvfi_rd_addr),
        .rvfi_rd_wdata       (rvfi_rd_wdata),
        .rvfi_trap           (rvfi_trap),
        .rvfi_intr           (rvfi_intr),
        .rvfi_ext_debug_mode (rvfi_ext_debug_mode),
        .trace_valid_o       (trace_valid_o),
        .trace_ready_i       (trace_ready_i),
        .trace_rec_o         (trace_rec_o),
        .level_o             (level_o),
        .drop_cnt_o          (drop_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Record fields are all derived from the pc so each vector is self-describing
    function automatic logic [104:0] mk(input logic [31:0] pc, input logic lost);
        return {pc, {pc[15:0], 16'h0013}, pc[6:2], ~pc, pc[2], pc[3], pc[4], lost};
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic en,
                         input logic fl, input logic acc, input logic lost,
                         input logic tsc, input logic [31:0] ts);
        exp_t e;
        rvfi_valid          = v;
        rvfi_pc_rdata       = pc;
        rvfi_insn           = {pc[15:0], 16'h0013};
        rvfi_rd_addr        = pc[6:2];
        rvfi_rd_wdata       = ~pc;
        rvfi_trap           = pc[2];
        rvfi_intr           = pc[3];
        rvfi_ext_debug_mode = pc[4];
        trace_ready_i       = rdy;
        enable_i            = en;
        flush_i             = fl;
        if (acc) begin
            e.bits   = mk(pc, lost);
            e.ts_chk = tsc;
            e.ts     = ts;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 32'h0, rdy, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic push(input logic [31:0] pc, input logic rdy, input logic acc, input logic lost);
        drive(1'b1, pc, rdy, 1'b1, 1'b0, acc, lost, 1'b0, 32'd0);
    endtask

    // Monitor: every record consumed by the handshake is compared with the scoreboard head
    always @(negedge clk) begin
        if (!rst && trace_valid_o && trace_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rec", 128'(trace_rec_o.pc), 128'hFFFF_FFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rec", 128'({trace_rec_o.pc, trace_rec_o.insn, trace_rec_o.rd_addr,
                                 trace_rec_o.rd_wdata, trace_rec_o.trap, trace_rec_o.intr,
                                 trace_rec_o.dbg, trace_rec_o.lost}), 128'(mon_e.bits));
`ifdef IBEX_TRACE_TSTAMP_EN
                if (mon_e.ts_chk) begin
                    chk("tstamp", 128'(trace_rec_o.tstamp), 128'(mon_e.ts));
                end
`endif
            end
        end
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("rst_valid", 128'(trace_valid_o), 128'd0);
        chk("rst_level", 128'(level_o), 128'd0);
        chk("rst_drop", 128'(drop_cnt_o), 128'd0);
        chk("rst_rec_zero", 128'(|trace_rec_o), 128'd0);
        rst = 1'b0;

        // Single push latency and timestamps at cycles 3 and 7
        repeat (3) idle(1'b0);
        drive(1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd3);
        chk("lat_valid", 128'(trace_valid_o), 128'd1);
        chk("lat_pc", 128'(trace_rec_o.pc), 128'h100);
        chk("lat_level", 128'(level_o), 128'd1);
        repeat (3) idle(1'b0);
        drive(1'b1, 32'h104, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd7);
        chk("two_level", 128'(level_o), 128'd2);
        repeat (2) idle(1'b1);
        chk("drain_level", 128'(level_o), 128'd0);
        chk("drain_valid", 128'(trace_valid_o), 128'd0);

        // Overflow: 10 pushes into 8 entries, then the next accepted record carries lost
        for (int i = 0; i < 10; i++) begin
            push(32'h300 + 32'(i * 4), 1'b0, (i < 8) ? 1'b1 : 1'b0, 1'b0);
        end
        chk("full_level", 128'(level_o), 128'd8);
        chk("full_drop", 128'(drop_cnt_o), 128'd2);
        chk("stall_head", 128'(trace_rec_o.pc), 128'h300);
        idle(1'b1);
        chk("pop1_level", 128'(level_o), 128'd7);
        push(32'h200, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            push(32'hD000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
        end
        chk("drop7", 128'(drop_cnt_o), 128'd7);
        for (int i = 0; i < 13; i++) begin
            push(32'hD100_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
        end
        chk("drop_sat", 128'(drop_cnt_o), 128'hF);

        // Full with simultaneous push and pop
        push(32'h400, 1'b1, 1'b1, 1'b1);
        chk("pp_level", 128'(level_o), 128'd8);
        chk("pp_drop", 128'(drop_cnt_o), 128'hF);
        push(32'h404, 1'b1, 1'b1, 1'b0);
        chk("pp2_level", 128'(level_o), 128'd8);

        // Drop to set lost, drain to 5, then flush with a retirement present
        push(32'hD200_0000, 1'b0, 1'b0, 1'b0);
        repeat (3) idle(1'b1);
        chk("pre_flush_level", 128'(level_o), 128'd5);
        drive(1'b1, 32'h480, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        exp_q.delete();
        chk("flush_level", 128'(level_o), 128'd0);
        chk("flush_valid", 128'(trace_valid_o), 128'd0);
        chk("flush_drop", 128'(drop_cnt_o), 128'd0);
        push(32'h500, 1'b0, 1'b1, 1'b0);
        chk("post_flush_level", 128'(level_o), 128'd1);
        idle(1'b1);
        idle(1'b0);

        // Disabled capture at full neither pushes nor counts a drop
        for (int i = 0; i < 8; i++) begin
            push(32'h600 + 32'(i * 4), 1'b0, 1'b1, 1'b0);
        end
        repeat (2) drive(1'b1, 32'hE000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("dis_drop", 128'(drop_cnt_o), 128'd0);
        chk("dis_level", 128'(level_o), 128'd8);
        push(32'hE100_0000, 1'b0, 1'b0, 1'b0);
        chk("en_drop", 128'(drop_cnt_o), 128'd1);

        // Reset mid-transfer discards contents and the pending lost mark
        rst = 1'b1;
        repeat (2) idle(1'b1);
        exp_q.delete();
        chk("mid_rst_level", 128'(level_o), 128'd0);
        chk("mid_rst_valid", 128'(trace_valid_o), 128'd0);
        chk("mid_rst_drop", 128'(drop_cnt_o), 128'd0);
        chk("mid_rst_rec", 128'(|trace_rec_o), 128'd0);
        rst = 1'b0;
        push(32'h700, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b0);
        chk("end_level", 128'(level_o), 128'd0);
        chk("sb_empty", 128'(exp_q.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
